// File: rtl/rv32i_pkg.sv
// Shared RV32I ALU-issue definitions: ALU op codes, opcode and funct7 constants, and the
// issue controller's FSM state encoding.
// base_op() maps funct3 to the ALU op for the funct7=0000000 row, which OP and OP-IMM share.
package rv32i_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_MUL  = 4'd2;
  localparam logic [3:0] ALU_DIV  = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_EQ   = 4'd9;
  localparam logic [3:0] ALU_LTU  = 4'd10;
  localparam logic [3:0] ALU_GEU  = 4'd11;
  localparam logic [3:0] ALU_JALR = 4'd12;
  localparam logic [3:0] ALU_SRA  = 4'd13;
  localparam logic [3:0] ALU_LT   = 4'd14;
  localparam logic [3:0] ALU_GE   = 4'd15;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic [3:0] base_op(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_LT;
      3'b011:  op = ALU_LTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_alu_decode.sv
// Purpose: combinational RV32I decode of OP/OP-IMM/LUI/AUIPC/JALR into ALU op and operands.
// Latency: none (pure combinational). Backpressure: none, the caller samples on its handshake.
// Ports: instr/pc/rs1_data/rs2_data in; op, a, b, rd, illegal, is_muldiv, is_jalr out.
module rv32i_alu_decode
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [3:0]  op,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [4:0]  rd,
  output logic        illegal,
  output logic        is_muldiv,
  output logic        is_jalr
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign shamt  = {27'b0, instr[24:20]};
  assign rd     = instr[11:7];

  always_comb begin
    op        = ALU_ADD;
    a         = rs1_data;
    b         = rs2_data;
    illegal   = 1'b0;
    is_muldiv = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OPC_OP: begin
        case (f7)
          F7_BASE: op = base_op(f3);
          F7_ALT: begin
            if (f3 == 3'b000)      op = ALU_SUB;
            else if (f3 == 3'b101) op = ALU_SRA;
            else                   illegal = 1'b1;
          end
          F7_MULDIV: begin
            is_muldiv = 1'b1;
            if (f3 == 3'b000)      op = ALU_MUL;
            else if (f3 == 3'b100) op = ALU_DIV;
            else                   illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        b = imm_i;
        // Only the shift forms carry a real funct7; elsewhere those bits are immediate.
        case (f3)
          3'b001: begin
            b = shamt;
            if (f7 == F7_BASE) op = ALU_SLL;
            else               illegal = 1'b1;
          end
          3'b101: begin
            b = shamt;
            if (f7 == F7_BASE)     op = ALU_SRL;
            else if (f7 == F7_ALT) op = ALU_SRA;
            else                   illegal = 1'b1;
          end
          default: op = base_op(f3);
        endcase
      end
      OPC_LUI: begin
        a = '0;
        b = imm_u;
      end
      OPC_AUIPC: begin
        a = pc;
        b = imm_u;
      end
      OPC_JALR: begin
        b = imm_i;
        if (f3 == 3'b000) begin
          op      = ALU_JALR;
          is_jalr = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
    // A rejected instruction must not look like a multi-cycle or link op downstream.
    if (illegal) begin
      is_muldiv = 1'b0;
      is_jalr   = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Purpose: issues one decoded RV32I instruction to the ALU and registers its writeback record.
// Latency: handshake->wb_valid 2 cycles, MULDIV_LAT+1 for MUL/DIV, 1 for illegal instructions.
// Backpressure: instr_ready only in IDLE; wb_* held stable while wb_valid && !wb_ready.
// Ports: clk/rst; instr_valid/instr_ready with instr, pc, rs1_data, rs2_data; alu_op/alu_a/alu_b
//        out, alu_result in; wb_valid/wb_ready with wb_we, wb_rd, wb_data, wb_illegal.
module alu_issue_ctrl
  import rv32i_pkg::*;
#(
  parameter int MULDIV_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_illegal
);

  localparam int CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       rd_q;
  logic             jalr_q;
  logic [31:0]      link_q;

  logic [3:0]  dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [4:0]  dec_rd;
  logic        dec_illegal;
  logic        dec_muldiv;
  logic        dec_jalr;
  logic        div_by_zero;

  rv32i_alu_decode u_decode (
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .op        (dec_op),
    .a         (dec_a),
    .b         (dec_b),
    .rd        (dec_rd),
    .illegal   (dec_illegal),
    .is_muldiv (dec_muldiv),
    .is_jalr   (dec_jalr)
  );

  // Divide-by-zero result is defined here rather than trusted to the ALU.
  assign div_by_zero = (alu_op == ALU_DIV) && (alu_b == 32'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rd_q        <= '0;
      jalr_q      <= 1'b0;
      link_q      <= '0;
      instr_ready <= 1'b1;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      wb_illegal  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_valid && instr_ready) begin
            instr_ready <= 1'b0;
            rd_q        <= dec_rd;
            if (dec_illegal) begin
              // Skip EXEC entirely; ALU operand registers keep their previous values.
              state      <= ST_RESP;
              wb_valid   <= 1'b1;
              wb_illegal <= 1'b1;
              wb_we      <= 1'b0;
              wb_rd      <= dec_rd;
              wb_data    <= '0;
            end else begin
              state  <= ST_EXEC;
              alu_op <= dec_op;
              alu_a  <= dec_a;
              alu_b  <= dec_b;
              cnt    <= dec_muldiv ? CNT_LOAD : '0;
              jalr_q <= dec_jalr;
              link_q <= pc + 32'd4;
            end
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
            state      <= ST_RESP;
            wb_valid   <= 1'b1;
            wb_illegal <= 1'b0;
            wb_we      <= (rd_q != 5'd0);
            wb_rd      <= rd_q;
            // JALR writes the link address; its ALU result is the jump target.
            if (jalr_q)           wb_data <= link_q;
            else if (div_by_zero) wb_data <= '1;
            else                  wb_data <= alu_result;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (wb_ready) begin
            state       <= ST_IDLE;
            wb_valid    <= 1'b0;
            instr_ready <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          wb_valid    <= 1'b0;
          instr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Purpose: self-checking bench for alu_issue_ctrl with a behavioural ALU and transaction model.
// Latency: model predicts wb_valid from handshake cycle plus per-instruction latency.
// Backpressure: wb_ready is held low for a chosen number of cycles per vector.
module tb_alu_issue_ctrl;

  localparam int MUL_LAT = 3;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_illegal;

  alu_issue_ctrl #(.MULDIV_LAT(MUL_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .pc          (pc),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_illegal  (wb_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment ALU; DIV by zero returns junk so the controller's override is visible.
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a * b;
      4'd3:  return (b == 0) ? 32'hDEAD_BEEF : $signed(a) / $signed(b);
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return a ^ b;
      4'd7:  return a << b[4:0];
      4'd8:  return a >> b[4:0];
      4'd9:  return {31'b0, a == b};
      4'd10: return {31'b0, a < b};
      4'd11: return {31'b0, a >= b};
      4'd12: return (a + b) & ~32'd1;
      4'd13: return $signed(a) >>> b[4:0];
      4'd14: return {31'b0, $signed(a) < $signed(b)};
      default: return {31'b0, $signed(a) >= $signed(b)};
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op, alu_a, alu_b);

  typedef struct {
    logic        legal;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic [4:0]  rd;
    int          lat;
  } pred_t;

  // Instruction-level prediction: mnemonic -> ALU op/operands, latency and written value.
  function automatic pred_t predict(input logic [31:0] ins, input logic [31:0] pcv,
                                    input logic [31:0] r1, input logic [31:0] r2);
    pred_t p;
    logic [31:0] imm_i;
    logic [31:0] shamt;
    imm_i   = {{20{ins[31]}}, ins[31:20]};
    shamt   = {27'b0, ins[24:20]};
    p.legal = 1'b1; p.op = 4'd0; p.a = r1; p.b = r2; p.rd = ins[11:7]; p.lat = 2; p.data = 0;
    case (ins[6:0])
      7'h33: case ({ins[31:25], ins[14:12]})
        10'b0000000_000: p.op = 4'd0;
        10'b0000000_001: p.op = 4'd7;
        10'b0000000_010: p.op = 4'd14;
        10'b0000000_011: p.op = 4'd10;
        10'b0000000_100: p.op = 4'd6;
        10'b0000000_101: p.op = 4'd8;
        10'b0000000_110: p.op = 4'd5;
        10'b0000000_111: p.op = 4'd4;
        10'b0100000_000: p.op = 4'd1;
        10'b0100000_101: p.op = 4'd13;
        10'b0000001_000: begin p.op = 4'd2; p.lat = MUL_LAT + 1; end
        10'b0000001_100: begin p.op = 4'd3; p.lat = MUL_LAT + 1; end
        default: p.legal = 1'b0;
      endcase
      7'h13: begin
        p.b = imm_i;
        case (ins[14:12])
          3'd0: p.op = 4'd0;
          3'd2: p.op = 4'd14;
          3'd3: p.op = 4'd10;
          3'd4: p.op = 4'd6;
          3'd6: p.op = 4'd5;
          3'd7: p.op = 4'd4;
          3'd1: begin
            p.b = shamt;
            if (ins[31:25] == 7'h00) p.op = 4'd7; else p.legal = 1'b0;
          end
          default: begin
            p.b = shamt;
            if (ins[31:25] == 7'h00)      p.op = 4'd8;
            else if (ins[31:25] == 7'h20) p.op = 4'd13;
            else                          p.legal = 1'b0;
          end
        endcase
      end
      7'h37: begin p.a = 0;   p.b = {ins[31:12], 12'b0}; end
      7'h17: begin p.a = pcv; p.b = {ins[31:12], 12'b0}; end
      7'h67: begin
        p.b = imm_i;
        if (ins[14:12] == 3'd0) p.op = 4'd12; else p.legal = 1'b0;
      end
      default: p.legal = 1'b0;
    endcase
    if (!p.legal) begin
      p.lat = 1; p.data = 0;
    end else if (p.op == 4'd12) p.data = pcv + 32'd4;
    else if (p.op == 4'd3 && p.b == 0) p.data = 32'hFFFF_FFFF;
    else p.data = alu_fn(p.op, p.a, p.b);
    return p;
  endfunction

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: one outstanding instruction, response visible lat cycles after handshake.
  int          cyc   = 0;
  int          acc   = 0;
  int          n_acc = 0;
  bit          busy  = 1'b0;
  bit          fresh = 1'b1;
  pred_t       cur;
  logic [3:0]  m_op  = 4'd0;
  logic [31:0] m_a   = 32'd0;
  logic [31:0] m_b   = 32'd0;

  function automatic bit resp_due();
    return busy && (cyc - acc >= cur.lat);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy = 1'b0; fresh = 1'b1; m_op = 4'd0; m_a = 32'd0; m_b = 32'd0;
    end else begin
      bit was_busy;
      was_busy = busy;
      if (resp_due() && wb_ready) busy = 1'b0;
      if (!was_busy && instr_valid) begin
        cur   = predict(instr, pc, rs1_data, rs2_data);
        busy  = 1'b1;
        fresh = 1'b0;
        acc   = cyc;
        n_acc++;
        if (cur.legal) begin
          m_op = cur.op; m_a = cur.a; m_b = cur.b;
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    bit ev;
    ev = resp_due();
    chk("instr_ready", {31'b0, instr_ready}, {31'b0, !busy});
    chk("wb_valid", {31'b0, wb_valid}, {31'b0, ev});
    chk("alu_op", {28'b0, alu_op}, {28'b0, m_op});
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    if (ev) begin
      chk("wb_illegal", {31'b0, wb_illegal}, {31'b0, !cur.legal});
      chk("wb_we", {31'b0, wb_we}, {31'b0, cur.legal && cur.rd != 0});
      chk("wb_data", wb_data, cur.data);
      if (cur.legal) chk("wb_rd", {27'b0, wb_rd}, {27'b0, cur.rd});
    end else if (fresh) begin
      chk("rst_wb_we", {31'b0, wb_we}, 32'd0);
      chk("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_wb_illegal", {31'b0, wb_illegal}, 32'd0);
    end
  end

  task automatic present(input logic [31:0] ins, input logic [31:0] pcv,
                         input logic [31:0] r1, input logic [31:0] r2);
    int n0;
    @(negedge clk);
    instr = ins; pc = pcv; rs1_data = r1; rs2_data = r2; instr_valid = 1'b1;
    n0 = n_acc;
    for (int i = 0; i < 20 && n_acc == n0; i++) begin
      @(posedge clk); #1;
    end
    if (n_acc == n0) begin
      n_fail++;
      $display("FAIL accept_timeout: instr %h not accepted", ins);
    end
    @(negedge clk);
    instr_valid = 1'b0;
    instr = 32'hFFFF_FFFF; rs1_data = 32'hA5A5_A5A5; rs2_data = 32'h5A5A_5A5A; pc = 32'hFFFF_FFF0;
  endtask

  task automatic run(input logic [31:0] ins, input logic [31:0] pcv, input logic [31:0] r1,
                     input logic [31:0] r2, input int hold, input bit lit_legal,
                     input logic [3:0] lit_op, input logic [31:0] lit_data);
    pred_t p;
    p = predict(ins, pcv, r1, r2);
    chk("pin_legal", {31'b0, p.legal}, {31'b0, lit_legal});
    chk("pin_data", p.data, lit_data);
    if (lit_legal) chk("pin_op", {28'b0, p.op}, {28'b0, lit_op});
    present(ins, pcv, r1, r2);
    for (int i = 0; i < 20; i++) begin
      if (resp_due()) break;
      @(negedge clk);
    end
    if (!resp_due()) begin
      n_fail++;
      $display("FAIL resp_timeout: instr %h never reached response", ins);
    end
    chk("lit_wb_data", wb_data, lit_data);
    if (lit_legal) chk("lit_alu_op", {28'b0, alu_op}, {28'b0, lit_op});
    repeat (hold) @(negedge clk);
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; instr_valid = 1'b0; wb_ready = 1'b0;
    instr = 0; pc = 0; rs1_data = 0; rs2_data = 0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    //   instr         pc          rs1           rs2           hold legal op  data
    run(32'h002081B3, 32'h0,     32'd5,         32'd7,         0, 1, 4'd0,  32'd12);      // ADD x3
    run(32'h4040D213, 32'h0,     32'h8000_0000, 32'd0,         0, 1, 4'd13, 32'hF800_0000); // SRAI
    run(32'h40309293, 32'h0,     32'd1,         32'd0,         0, 0, 4'd0,  32'd0);       // SLLI f7=SUB
    run(32'h02208333, 32'h0,     32'h0001_2345, 32'h0001_0000, 0, 1, 4'd2,  32'h2345_0000); // MUL
    run(32'h0220C3B3, 32'h0,     32'd100,       32'd0,         0, 1, 4'd3,  32'hFFFF_FFFF); // DIV /0
    run(32'h0220C3B3, 32'h0,     32'd100,       32'd7,         1, 1, 4'd3,  32'd14);      // DIV
    run(32'h008280E7, 32'h100,   32'h201,       32'd0,         0, 1, 4'd12, 32'h104);     // JALR
    run(32'h00208033, 32'h0,     32'd1,         32'd2,         0, 1, 4'd0,  32'd3);       // ADD x0
    run(32'h002081B3, 32'h0,     32'd5,         32'd7,         5, 1, 4'd0,  32'd12);      // stall 5
    run(32'h00208063, 32'h0,     32'd1,         32'd1,         2, 0, 4'd0,  32'd0);       // BEQ
    run(32'h12345437, 32'h0,     32'd9,         32'd9,         0, 1, 4'd0,  32'h1234_5000); // LUI
    run(32'h00001497, 32'h200,   32'd0,         32'd0,         0, 1, 4'd0,  32'h1200);    // AUIPC
    run(32'hFFF08513, 32'h0,     32'd5,         32'd0,         0, 1, 4'd0,  32'd4);       // ADDI -1
    run(32'h402085B3, 32'h0,     32'd5,         32'd7,         0, 1, 4'd1,  32'hFFFF_FFFE); // SUB
    run(32'h0020A633, 32'h0,     32'hFFFF_FFFF, 32'd1,         0, 1, 4'd14, 32'd1);       // SLT
    run(32'h0020B633, 32'h0,     32'hFFFF_FFFF, 32'd1,         0, 1, 4'd10, 32'd0);       // SLTU
    run(32'h02209633, 32'h0,     32'd3,         32'd4,         0, 0, 4'd0,  32'd0);       // MULH

    // Reset in the middle of a MUL execution.
    present(32'h02208333, 32'h0, 32'd6, 32'd7);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("midrst_instr_ready", {31'b0, instr_ready}, 32'd1);
    chk("midrst_alu_a", alu_a, 32'd0);
    chk("midrst_alu_op", {28'b0, alu_op}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    run(32'h002081B3, 32'h0, 32'd20, 32'd22, 0, 1, 4'd0, 32'd42);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
